// File: rtl/alu_muldiv_if.sv
// Execute-stage bus between the CPU datapath and alu_muldiv.
// Latency: none, wires only.
// Backpressure: md_busy tells the control unit to stall; md_start is ignored while busy.
interface alu_muldiv_if #(
    parameter int bit_size   = 32,
    parameter int shamt_size = 5
);
    logic [3:0]            ALUCtrl;
    logic [bit_size-1:0]   src1;
    logic [bit_size-1:0]   src2;
    logic [shamt_size-1:0] shamt;
    logic [bit_size-1:0]   ALU_result;
    logic                  Zero;
    logic                  md_start;
    logic [1:0]            md_op;
    logic                  md_busy;
    logic                  md_done;
    logic [bit_size-1:0]   HI;
    logic [bit_size-1:0]   LO;

    modport master (
        output ALUCtrl, src1, src2, shamt, md_start, md_op,
        input  ALU_result, Zero, md_busy, md_done, HI, LO
    );

    modport slave (
        input  ALUCtrl, src1, src2, shamt, md_start, md_op,
        output ALU_result, Zero, md_busy, md_done, HI, LO
    );
endinterface

// File: rtl/alu_muldiv.sv
// Combinational ALU plus iterative shift-add multiplier / restoring divider with HI/LO.
// Latency: ALU zero cycles; mul/div bit_size edges from accept to the md_done pulse.
// Backpressure: md_busy high while iterating; md_start is only sampled when idle.
module alu_muldiv #(
    parameter int bit_size   = 32,
    parameter int shamt_size = 5
) (
    input  logic          clk,
    input  logic          rst,
    alu_muldiv_if.slave   bus
);
    localparam int W = bit_size;
    localparam logic [shamt_size-1:0] LAST_ITER = shamt_size'(W - 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                state, state_nxt;
    logic                  last_step;
    logic [W-1:0]          alu_res;
    logic                  alu_zero;
    logic [shamt_size-1:0] vamt;

    logic                  op_div, neg_q, neg_r, done;
    logic [shamt_size-1:0] count;
    logic [W-1:0]          acc, mq, opb, hi, lo;

    logic                  a_neg, b_neg;
    logic [W-1:0]          a_mag, b_mag;
    logic [W:0]            mul_sum, div_shift, div_diff;
    logic                  div_ok;
    logic [W-1:0]          acc_n, mq_n, q_s, r_s, hi_fix, lo_fix;
    logic [2*W-1:0]        prod, prod_s;

    assign vamt = bus.src1[shamt_size-1:0];

    always_comb begin
        alu_res = '0;
        case (bus.ALUCtrl)
            4'b0010: alu_res = bus.src1 + bus.src2;
            4'b0110,
            4'b1110: alu_res = bus.src1 - bus.src2;
            4'b0000: alu_res = bus.src1 & bus.src2;
            4'b0001: alu_res = bus.src1 | bus.src2;
            4'b1100: alu_res = ~(bus.src1 | bus.src2);
            4'b0011: alu_res = bus.src1 ^ bus.src2;
            4'b0111: alu_res = {{(W-1){1'b0}}, $signed(bus.src1) < $signed(bus.src2)};
            4'b0101: alu_res = {{(W-1){1'b0}}, bus.src1 < bus.src2};
            4'b1000: alu_res = bus.src2 << bus.shamt;
            4'b1001: alu_res = bus.src2 >> bus.shamt;
            4'b0100: alu_res = $signed(bus.src2) >>> bus.shamt;
            4'b1010: alu_res = bus.src2 << vamt;
            4'b1011: alu_res = bus.src2 >> vamt;
            4'b1101: alu_res = $signed(bus.src2) >>> vamt;
            default: alu_res = '0;
        endcase
        // bne reuses the subtractor, so its branch flag is the inverted zero test
        alu_zero = (bus.ALUCtrl == 4'b1110) ? (alu_res != '0) : (alu_res == '0);
    end

    assign bus.ALU_result = alu_res;
    assign bus.Zero       = alu_zero;

    // Operands are iterated as magnitudes; signs are restored at the done edge.
    assign a_neg = ~bus.md_op[0] & bus.src1[W-1];
    assign b_neg = ~bus.md_op[0] & bus.src2[W-1];
    assign a_mag = a_neg ? -bus.src1 : bus.src1;
    assign b_mag = b_neg ? -bus.src2 : bus.src2;

    always_comb begin
        mul_sum   = {1'b0, acc} + (mq[0] ? {1'b0, opb} : '0);
        div_shift = {acc, mq[W-1]};
        div_diff  = div_shift - {1'b0, opb};
        div_ok    = ~div_diff[W];
        if (op_div) begin
            acc_n = div_ok ? div_diff[W-1:0] : div_shift[W-1:0];
            mq_n  = {mq[W-2:0], div_ok};
        end else begin
            acc_n = mul_sum[W:1];
            mq_n  = {mul_sum[0], mq[W-1:1]};
        end
        prod   = {acc_n, mq_n};
        prod_s = neg_q ? -prod : prod;
        q_s    = neg_q ? -mq_n : mq_n;
        r_s    = neg_r ? -acc_n : acc_n;
        hi_fix = op_div ? r_s : prod_s[2*W-1:W];
        lo_fix = op_div ? q_s : prod_s[W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        last_step = 1'b0;
        if (state == S_IDLE) begin
            if (bus.md_start) state_nxt = S_RUN;
        end else if (count == LAST_ITER) begin
            last_step = 1'b1;
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            done   <= 1'b0;
            count  <= '0;
            acc    <= '0;
            mq     <= '0;
            opb    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (bus.md_start) begin
                    op_div <= bus.md_op[1];
                    // divide-by-zero keeps the all-ones quotient unsigned
                    neg_q  <= (a_neg ^ b_neg) & (~bus.md_op[1] | (|bus.src2));
                    neg_r  <= a_neg;
                    count  <= '0;
                    acc    <= '0;
                    mq     <= a_mag;
                    opb    <= b_mag;
                end
            end else begin
                acc   <= acc_n;
                mq    <= mq_n;
                count <= count + 1'b1;
                if (last_step) begin
                    hi   <= hi_fix;
                    lo   <= lo_fix;
                    done <= 1'b1;
                end
            end
        end
    end

    assign bus.md_busy = (state == S_RUN);
    assign bus.md_done = done;
    assign bus.HI      = hi;
    assign bus.LO      = lo;
endmodule

// File: tb/tb_alu_muldiv.sv
// Exercises 32-bit and 16-bit alu_muldiv instances, one suite each, against a reference model.
module tb_alu_muldiv;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_muldiv_if #(.bit_size(32), .shamt_size(5)) bus32();
    alu_muldiv_if #(.bit_size(16), .shamt_size(4)) bus16();

    alu_muldiv #(.bit_size(32), .shamt_size(5)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));
    alu_muldiv #(.bit_size(16), .shamt_size(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

    logic [3:0]  ctrl;
    logic [63:0] s1, s2;
    logic [4:0]  sh;
    logic        start;
    logic [1:0]  op;

    assign bus32.ALUCtrl  = ctrl;
    assign bus32.src1     = s1[31:0];
    assign bus32.src2     = s2[31:0];
    assign bus32.shamt    = sh;
    assign bus32.md_start = start;
    assign bus32.md_op    = op;
    assign bus16.ALUCtrl  = ctrl;
    assign bus16.src1     = s1[15:0];
    assign bus16.src2     = s2[15:0];
    assign bus16.shamt    = sh[3:0];
    assign bus16.md_start = start;
    assign bus16.md_op    = op;

    int          cur_w = 32;
    logic [63:0] o_res, o_hi, o_lo;
    logic        o_zero, o_busy, o_done;

    always_comb begin
        if (cur_w == 16) begin
            o_res  = {48'd0, bus16.ALU_result};
            o_hi   = {48'd0, bus16.HI};
            o_lo   = {48'd0, bus16.LO};
            o_zero = bus16.Zero;
            o_busy = bus16.md_busy;
            o_done = bus16.md_done;
        end else begin
            o_res  = {32'd0, bus32.ALU_result};
            o_hi   = {32'd0, bus32.HI};
            o_lo   = {32'd0, bus32.LO};
            o_zero = bus32.Zero;
            o_busy = bus32.md_busy;
            o_done = bus32.md_done;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        int          due;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          failures = 0;
    logic [63:0] last_hi, last_lo;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] msk(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic longint sx(input int w, input logic [63:0] v);
        logic [63:0] t;
        t = v & msk(w);
        return t[w-1] ? longint'(t) - longint'(64'd1 << w) : longint'(t);
    endfunction

    function automatic void alu_model(input int w, input logic [3:0] c, input logic [63:0] a,
                                      input logic [63:0] b, input int shv,
                                      output logic [63:0] r, output logic z);
        logic [63:0] m;
        int          s, va;
        m  = msk(w);
        s  = shv & (w - 1);
        va = int'(a) & (w - 1);
        case (c)
            4'b0010: r = (a + b) & m;
            4'b0110, 4'b1110: r = (a - b) & m;
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b1100: r = ~(a | b) & m;
            4'b0011: r = a ^ b;
            4'b0111: r = (sx(w, a) < sx(w, b)) ? 64'd1 : 64'd0;
            4'b0101: r = (a < b) ? 64'd1 : 64'd0;
            4'b1000: r = (b << s) & m;
            4'b1001: r = b >> s;
            4'b0100: r = 64'(sx(w, b) >>> s) & m;
            4'b1010: r = (b << va) & m;
            4'b1011: r = b >> va;
            4'b1101: r = 64'(sx(w, b) >>> va) & m;
            default: r = 64'd0;
        endcase
        z = (c == 4'b1110) ? (r != 0) : (r == 0);
    endfunction

    function automatic void md_model(input int w, input logic [1:0] o, input logic [63:0] a,
                                     input logic [63:0] b, output logic [63:0] hi,
                                     output logic [63:0] lo);
        logic [63:0] m, u;
        longint      x, y, p;
        m = msk(w);
        x = sx(w, a);
        y = sx(w, b);
        case (o)
            2'b00: begin
                p  = x * y;
                lo = 64'(p) & m;
                hi = 64'(p >>> w) & m;
            end
            2'b01: begin
                u  = a * b;
                lo = u & m;
                hi = (u >> w) & m;
            end
            2'b10: begin
                if (b == 0) begin
                    lo = m;
                    hi = a;
                end else begin
                    p  = x / y;
                    lo = 64'(p) & m;
                    p  = x % y;
                    hi = 64'(p) & m;
                end
            end
            default: begin
                if (b == 0) begin
                    lo = m;
                    hi = a;
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && o_done) begin
                if (sbq.size() == 0) begin
                    chk("spurious_done", {63'd0, o_done}, 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("md_hi", o_hi, e.hi);
                    chk("md_lo", o_lo, e.lo);
                    chk("md_latency", 64'(cyc), 64'(e.due));
                end
            end
        end
    endtask

    task automatic alu_case(input int w, input string tag, input logic [3:0] c,
                            input logic [63:0] a, input logic [63:0] b, input int shv);
        logic [63:0] r;
        logic        z;
        ctrl = c;
        s1   = a & msk(w);
        s2   = b & msk(w);
        sh   = 5'(shv);
        #1;
        alu_model(w, c, a & msk(w), b & msk(w), shv, r, z);
        chk(tag, o_res, r);
        chk({tag, "_zero"}, {63'd0, o_zero}, {63'd0, z});
    endtask

    // Caller is at a negedge; returns just after the accept edge.
    task automatic md_issue(input int w, input logic [1:0] o, input logic [63:0] a,
                            input logic [63:0] b, output logic [63:0] ehi,
                            output logic [63:0] elo);
        md_model(w, o, a & msk(w), b & msk(w), ehi, elo);
        s1    = a & msk(w);
        s2    = b & msk(w);
        op    = o;
        start = 1'b1;
        sbq.push_back('{ehi, elo, cyc + 1 + w});
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_accept", {63'd0, o_busy}, 64'd1);
        chk("hold_hi", o_hi, last_hi);
        chk("hold_lo", o_lo, last_lo);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            chk("done_timeout", 64'(sbq.size()), 64'd0);
            sbq.delete();
        end
    endtask

    task automatic md_run(input int w, input logic [1:0] o, input logic [63:0] a,
                          input logic [63:0] b);
        logic [63:0] ehi, elo;
        @(negedge clk);
        md_issue(w, o, a, b, ehi, elo);
        wait_idle(w + 8);
        last_hi = ehi;
        last_lo = elo;
    endtask

    task automatic run_suite(input int w);
        logic [63:0] m, mn, ehi, elo, ahi, alo;
        int          n;
        m  = msk(w);
        mn = 64'd1 << (w - 1);
        cur_w = w;
        rst = 1'b1;
        start = 1'b0;
        op = 2'b00;
        repeat (2) @(negedge clk);
        chk("rst_hi", o_hi, 64'd0);
        chk("rst_lo", o_lo, 64'd0);
        chk("rst_busy", {63'd0, o_busy}, 64'd0);
        chk("rst_done", {63'd0, o_done}, 64'd0);
        rst = 1'b0;
        last_hi = 64'd0;
        last_lo = 64'd0;

        alu_case(w, "add_wrap", 4'b0010, m, 64'd1, 0);
        alu_case(w, "sub_wrap", 4'b0110, 64'd0, 64'd1, 0);
        alu_case(w, "and", 4'b0000, {$urandom, $urandom}, {$urandom, $urandom}, 0);
        alu_case(w, "or", 4'b0001, {$urandom, $urandom}, {$urandom, $urandom}, 0);
        alu_case(w, "nor", 4'b1100, {$urandom, $urandom}, {$urandom, $urandom}, 0);
        alu_case(w, "xor", 4'b0011, {$urandom, $urandom}, {$urandom, $urandom}, 0);
        alu_case(w, "slt", 4'b0111, m, 64'd1, 0);
        chk("slt_k", o_res, 64'd1);
        alu_case(w, "sltu", 4'b0101, m, 64'd1, 0);
        chk("sltu_k", o_res, 64'd0);
        alu_case(w, "slt_rev", 4'b0111, 64'd1, m, 0);
        alu_case(w, "sll", 4'b1000, 64'd0, 64'h81, 3);
        alu_case(w, "srl", 4'b1001, 64'd0, mn | 64'd1, w - 1);
        alu_case(w, "sra", 4'b0100, 64'd0, mn | 64'h10, 4);
        chk("sra_k", o_res, (w == 32) ? 64'hF800_0001 : 64'hF801);
        alu_case(w, "srav", 4'b1101, 64'h24, mn | 64'h10, 0);
        chk("srav_k", o_res, (w == 32) ? 64'hF800_0001 : 64'hF801);
        alu_case(w, "sllv", 4'b1010, 64'hFFFF_FFE3, 64'h8001, 0);
        alu_case(w, "srlv", 4'b1011, 64'hFFFF_FFE5, m, 0);
        alu_case(w, "bne_eq", 4'b1110, 64'd5, 64'd5, 0);
        chk("bne_eq_zero_k", {63'd0, o_zero}, 64'd0);
        alu_case(w, "bne_ne", 4'b1110, 64'd5, 64'd6, 0);
        alu_case(w, "unlisted", 4'b1111, 64'd7, 64'd9, 0);
        chk("unlisted_res_k", o_res, 64'd0);
        chk("unlisted_zero_k", {63'd0, o_zero}, 64'd1);

        md_run(w, 2'b00, -64'sd3, 64'd7);
        chk("mult_hi_k", o_hi, m);
        chk("mult_lo_k", o_lo, 64'hFFFF_FFFF_FFFF_FFEB & m);
        md_run(w, 2'b01, m, 64'd2);
        chk("multu_hi_k", o_hi, 64'd1);
        chk("multu_lo_k", o_lo, m - 64'd1);
        md_run(w, 2'b10, -64'sd7, 64'd2);
        chk("div_lo_k", o_lo, 64'hFFFF_FFFF_FFFF_FFFD & m);
        chk("div_hi_k", o_hi, m);
        md_run(w, 2'b11, 64'd100, 64'd7);
        chk("divu_lo_k", o_lo, 64'd14);
        chk("divu_hi_k", o_hi, 64'd2);
        md_run(w, 2'b10, mn, m);
        chk("div_ovf_lo_k", o_lo, mn);
        chk("div_ovf_hi_k", o_hi, 64'd0);
        md_run(w, 2'b11, 64'd5, 64'd0);
        chk("divu0_lo_k", o_lo, m);
        chk("divu0_hi_k", o_hi, 64'd5);
        md_run(w, 2'b10, -64'sd9, 64'd0);
        md_run(w, 2'b10, 64'd7, -64'sd2);
        md_run(w, 2'b10, -64'sd8, 64'd3);
        md_run(w, 2'b00, mn, mn);
        for (int i = 0; i < 6; i++)
            md_run(w, 2'($urandom_range(3)), {$urandom, $urandom}, {$urandom, $urandom});

        // start re-pulsed mid-operation must not disturb the running op
        @(negedge clk);
        md_issue(w, 2'b00, 64'd123, -64'sd5, ehi, elo);
        repeat (9) @(posedge clk);
        #1;
        s1 = 64'd999;
        s2 = 64'd3;
        op = 2'b11;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_ignore", {63'd0, o_busy}, 64'd1);
        wait_idle(w + 8);
        last_hi = ehi;
        last_lo = elo;

        // start offered in the done cycle is accepted on the next edge
        @(negedge clk);
        md_issue(w, 2'b11, 64'd1000, 64'd9, ahi, alo);
        n = 0;
        while (!o_done && n < w + 8) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_done_seen", {63'd0, o_done}, 64'd1);
        last_hi = ahi;
        last_lo = alo;
        md_issue(w, 2'b00, -64'sd11, 64'd13, ehi, elo);
        wait_idle(w + 8);
        last_hi = ehi;
        last_lo = elo;

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        md_issue(w, 2'b01, 64'd77, 64'd55, ehi, elo);
        repeat (15) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_hi", o_hi, 64'd0);
        chk("mid_rst_lo", o_lo, 64'd0);
        chk("mid_rst_busy", {63'd0, o_busy}, 64'd0);
        chk("mid_rst_done", {63'd0, o_done}, 64'd0);
        sbq.delete();
        last_hi = 64'd0;
        last_lo = 64'd0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (w + 6) @(negedge clk);
        md_run(w, 2'b10, -64'sd100, 64'd7);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        ctrl  = 4'b0000;
        s1    = 64'd0;
        s2    = 64'd0;
        sh    = 5'd0;
        op    = 2'b00;
        fork
            monitor();
        join_none
        run_suite(32);
        run_suite(16);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Next-generation execute-stage ALU for the single-cycle CPU.
- Keeps the combinational ALU path, parametrised in width, and adds signed and variable shifts and sltu.
- Adds an iterative multiply/divide unit with a start/busy/done handshake and HI/LO registers.
- Sits between the register-file read ports and the writeback mux. The control unit stalls the PC while md_busy is high.

Parameters:
- bit_size, 32, datapath width (even, >= 4).
- shamt_size, 5, shift-amount width; must equal log2(bit_size).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ALUCtrl  input  4  combinational operation select.
- src1  input  bit_size  operand A (rs).
- src2  input  bit_size  operand B (rt or immediate).
- shamt  input  shamt_size  immediate shift amount.
- ALU_result  output  bit_size  combinational result.
- Zero  output  1  branch flag.
- md_start  input  1  request a mul/div on src1, src2.
- md_op  input  2  00 mult, 01 multu, 10 div, 11 divu.
- md_busy  output  1  operation in progress.
- md_done  output  1  one-cycle pulse when HI/LO are updated.
- HI  output  bit_size  product upper half / remainder.
- LO  output  bit_size  product lower half / quotient.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - HI=0, LO=0, md_busy=0, md_done=0; iteration counter and all internal operand/accumulator registers cleared.
  - Any operation in progress is discarded.
  - ALU_result and Zero stay combinational and are unaffected.
- Combinational ALU, zero latency. Result is 0 for any unlisted code.
  - 0010 add: src1+src2, wraps modulo 2^bit_size.
  - 0110 sub: src1-src2, wraps.
  - 1110 sub for bne.
  - 0000 and, 0001 or, 1100 nor, 0011 xor.
  - 0111 slt: signed compare, result 1 or 0. 0101 sltu: unsigned compare.
  - 1000 sll, 1001 srl, 0100 sra: src2 shifted by shamt.
  - 1010 sllv, 1011 srlv, 1101 srav: src2 shifted by src1[shamt_size-1:0]; upper bits of src1 ignored.
  - sra/srav replicate src2 MSB.
- Zero:
  - Zero=(ALU_result==0) for every code except 1110, where Zero=(ALU_result!=0).
  - For unlisted codes Zero=1.
- Mul/div handshake:
  - md_start is sampled at a rising edge only when md_busy=0. md_start while busy is ignored and has no effect on the running operation.
  - Edge E0 (accept): latch md_op; load operands as magnitudes (signed ops) or raw values (unsigned ops); record the result sign(s); set md_busy=1; counter=0.
  - Edges E1..E(bit_size): one iteration per edge.
    - Multiply: shift-add, one multiplier bit per edge.
    - Divide: restoring division, one quotient bit per edge.
  - Edge E(bit_size): write HI/LO with final sign correction applied; md_busy=0; md_done=1.
  - Edge E(bit_size+1): md_done=0, unless it is the accept edge of a new operation, in which case md_done also returns to 0.
  - Total latency: start edge to done pulse = bit_size edges; md_done is high for exactly one cycle.
  - HI/LO hold their previous values for the whole operation and change only at the done edge.
  - Back-to-back: md_start high in the md_done cycle is accepted on the next edge.
- Arithmetic rules:
  - mult/multu: {HI,LO} = full 2*bit_size-bit product, signed or unsigned per md_op.
  - div/divu: LO=quotient, truncated toward zero; HI=remainder, taking the sign of the dividend.
  - Signed overflow (most-negative / -1): LO=most-negative, HI=0.
  - Divide by zero, signed or unsigned: LO=all ones, HI=dividend, src1 raw. Same latency, md_done still pulses.

Test Plan:
- ALU sweep, bit_size=32:
  - sra 0x80000010 by 4 -> 0xF8000001.
  - srav with src1=0x00000024 uses amount 4 -> same result.
  - slt 0xFFFFFFFF vs 1 -> 1; sltu on the same operands -> 0.
  - 1110 with equal operands -> Zero=0.
  - Unlisted code 1111 -> result 0, Zero=1.
- mult -3 x 7:
  - md_start at E0 -> md_busy high for 32 cycles, md_done at E32.
  - HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - multu 0xFFFFFFFF x 2 -> HI=1, LO=0xFFFFFFFE.
- Divide:
  - div -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu 100 / 7 -> LO=14, HI=2.
  - div 0x80000000 / -1 -> LO=0x80000000, HI=0.
- Divide by zero: divu 5 / 0 -> LO=0xFFFFFFFF, HI=5, done at E32.
- Handshake:
  - md_start re-pulsed at E10 with different operands -> ignored; the first result is correct.
  - md_start held high during the done cycle -> second operation starts, done again exactly 32 edges later.
- Reset mid-operation:
  - Assert rst at E15 between edges -> HI/LO/md_busy/md_done go to 0 immediately; no md_done pulse afterwards.
  - New operation after rst deasserts completes correctly.
  - Repeat the whole suite with bit_size=16, shamt_size=4.
